// File: rtl/wt_ctrl_pkg.sv
// Shared types and helpers for the weight-load sequencer: FSM states,
// BRAM address field widths and the {col,row} address packer.
package wt_ctrl_pkg;

  localparam int COL_BITS = 4;
  localparam int ROW_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    WAIT = 2'd3
  } wt_state_e;

  function automatic logic [COL_BITS+ROW_BITS-1:0] pack_addr(
    input logic [COL_BITS-1:0] col,
    input logic [ROW_BITS-1:0] row
  );
    return {col, row};
  endfunction

endpackage

// File: rtl/wt_addr_gen.sv
// Row/column walker for the weight BRAM. Rows advance fastest; bounds are
// latched on clear and final_o marks the last programmed location.
module wt_addr_gen
  import wt_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                step_i,
  input  logic [8:0]          rows_i,
  input  logic [4:0]          cols_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [COL_BITS-1:0] col_o,
  output logic                final_o
);

  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [8:0]          rows_q;
  logic [4:0]          cols_q;
  logic                row_last;
  logic                col_last;

  // Bounds are kept as counts (1..256 / 1..16), so compare index+1 at full width.
  assign row_last = ({1'b0, row_q} + 9'd1) == rows_q;
  assign col_last = ({1'b0, col_q} + 5'd1) == cols_q;
  assign final_o  = row_last && col_last;
  assign row_o    = row_q;
  assign col_o    = col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      rows_q <= '0;
      cols_q <= '0;
    end else if (clear_i) begin
      row_q  <= '0;
      col_q  <= '0;
      rows_q <= rows_i;
      cols_q <= cols_i;
    end else if (step_i) begin
      if (row_last) begin
        row_q <= '0;
        col_q <= col_q + 4'd1;
      end else begin
        row_q <= row_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/wt_load_ctrl.sv
// Weight BRAM loader: streams bytes into port A, pulses sa_start_o when the
// layer's weights are in, then waits for conv_done_i. Optional running
// byte checksum under WT_LOAD_CHECKSUM_EN.
module wt_load_ctrl
  import wt_ctrl_pkg::*;
#(
  parameter int COL_NUM    = 16,
  parameter int ROW_DEPTH  = 256,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [8:0]            cfg_rows_i,
  input  logic [4:0]            cfg_cols_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  input  logic                  conv_done_i,
  output logic                  wea_o,
  output logic [ADDR_WIDTH-1:0] addra_o,
  output logic [DATA_WIDTH-1:0] dia_o,
  output logic                  sa_start_o,
  output logic                  busy_o,
  output logic                  err_o
`ifdef WT_LOAD_CHECKSUM_EN
  ,
  output logic [15:0]           checksum_o
`endif
);

  localparam logic [8:0] MAX_ROWS = 9'(ROW_DEPTH);
  localparam logic [4:0] MAX_COLS = 5'(COL_NUM);

  wt_state_e             state_q;
  logic                  wea_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dia_q;
  logic                  sa_start_q;
  logic                  err_q;

  logic                  cfg_ok;
  logic                  start_ok;
  logic                  beat;
  logic [ROW_BITS-1:0]   row;
  logic [COL_BITS-1:0]   col;
  logic                  final_beat;

  assign cfg_ok   = (cfg_rows_i != 9'd0) && (cfg_rows_i <= MAX_ROWS) &&
                    (cfg_cols_i != 5'd0) && (cfg_cols_i <= MAX_COLS);
  assign start_ok = (state_q == IDLE) && start_i && cfg_ok;

  // Stream handshake: a byte transfers on a cycle where s_valid_i and
  // s_ready_o are both high; ready depends only on state (high in LOAD).
  assign s_ready_o = (state_q == LOAD);
  assign beat      = s_valid_i && s_ready_o;

  wt_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear_i (start_ok),
    .step_i  (beat),
    .rows_i  (cfg_rows_i),
    .cols_i  (cfg_cols_i),
    .row_o   (row),
    .col_o   (col),
    .final_o (final_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wea_q      <= 1'b0;
      addr_q     <= '0;
      dia_q      <= '0;
      sa_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wea_q      <= 1'b0;
      sa_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              err_q   <= 1'b0;
              state_q <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            wea_q  <= 1'b1;
            addr_q <= pack_addr(col, row);
            dia_q  <= s_data_i;
            // Start pulse is raised together with the final write so the
            // SA never sees it before the last byte is committed.
            if (final_beat || s_last_i) begin
              state_q    <= DONE;
              sa_start_q <= 1'b1;
              if (final_beat != s_last_i) err_q <= 1'b1;
            end
          end
        end
        DONE: state_q <= WAIT;
        WAIT: if (conv_done_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wea_o      = wea_q;
  assign addra_o    = addr_q;
  assign dia_o      = dia_q;
  assign sa_start_o = sa_start_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);

`ifdef WT_LOAD_CHECKSUM_EN
  logic [15:0] csum_q;
  logic [15:0] csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok)  csum_d = '0;
    else if (beat) csum_d = csum_q + 16'(s_data_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_wt_load_ctrl.sv
// Directed-plus-random bench for wt_load_ctrl: a reference model turns every
// accepted byte into its expected BRAM write and checks the write port.
module tb_wt_load_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [8:0]  cfg_rows_i;
  logic [4:0]  cfg_cols_i;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic        conv_done_i;
  logic        wea_o;
  logic [11:0] addra_o;
  logic [7:0]  dia_o;
  logic        sa_start_o;
  logic        busy_o;
  logic        err_o;
`ifdef WT_LOAD_CHECKSUM_EN
  logic [15:0] checksum_o;
`endif

  wt_load_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .cfg_rows_i  (cfg_rows_i),
    .cfg_cols_i  (cfg_cols_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .conv_done_i (conv_done_i),
    .wea_o       (wea_o),
    .addra_o     (addra_o),
    .dia_o       (dia_o),
    .sa_start_o  (sa_start_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
`ifdef WT_LOAD_CHECKSUM_EN
    ,
    .checksum_o  (checksum_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];   // {addr, data} of each expected BRAM write
  int          n_checks = 0;
  int          n_fail   = 0;
  int          sa_cnt   = 0;
  int          load_idx = 0;
  int          cur_rows = 1;
  logic [15:0] csum_m   = '0;
  logic        beat_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A write must follow a handshake by exactly one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) beat_q <= 1'b0;
    else     beat_q <= s_valid_i && s_ready_o;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("wea_latency", {31'd0, wea_o}, {31'd0, beat_q});
      if (wea_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(addra_o), 32'hFFFF_FFFF);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(addra_o), 32'(e[19:8]));
          chk("wr_data", 32'(dia_o), 32'(e[7:0]));
        end
      end
      if (sa_start_o) begin
        sa_cnt++;
        chk("sa_after_last_write", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int rows, input int cols);
    @(negedge clk);
    start_i    = 1'b1;
    cfg_rows_i = 9'(rows);
    cfg_cols_i = 5'(cols);
    @(negedge clk);
    start_i = 1'b0;
    if (rows >= 1 && rows <= 256 && cols >= 1 && cols <= 16) begin
      load_idx = 0;
      cur_rows = rows;
      csum_m   = '0;
    end
  endtask

  // Sends n bytes (counting pattern or random), last flagged on byte last_at
  // (0 = never), each beat preceded by random idle cycles at rate 100-pct.
  task automatic send_bytes(input int n, input int last_at, input int pct, input bit counting);
    for (int i = 1; i <= n; i++) begin
      logic [7:0] d;
      int         tries;
      bit         r;
      d = counting ? 8'(i) : 8'($urandom);
      while ($urandom_range(1, 100) > pct) begin
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        @(negedge clk);
      end
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_last_i  = (i == last_at);
      tries = 0;
      forever begin
        r = s_ready_o;
        @(posedge clk);
        if (r) begin
          int a;
          a = (load_idx / cur_rows) * 256 + (load_idx % cur_rows);
          exp_q.push_back({12'(a), d});
          load_idx++;
          csum_m = csum_m + 16'(d);
          @(negedge clk);
          break;
        end
        @(negedge clk);
        tries++;
        if (tries > 50) begin
          chk("ready_timeout", 32'(tries), 32'd0);
          break;
        end
      end
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic conv_done_pulse();
    @(negedge clk);
    conv_done_i = 1'b1;
    @(negedge clk);
    conv_done_i = 1'b0;
  endtask

  // Checks the post-load state once DONE has passed and the FSM sits in WAIT.
  task automatic check_after_load(input string tag, input int exp_sa, input bit exp_err);
    repeat (4) @(negedge clk);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_sa_count"}, 32'(sa_cnt), 32'(exp_sa));
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    chk({tag, "_busy_wait"}, {31'd0, busy_o}, 32'd1);
    chk({tag, "_ready_wait"}, {31'd0, s_ready_o}, 32'd0);
`ifdef WT_LOAD_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(checksum_o), 32'(csum_m));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          sa_before;
    logic [15:0] ref_sum;

    rst = 1'b1; start_i = 1'b0; cfg_rows_i = '0; cfg_cols_i = '0;
    s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0; conv_done_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wea", {31'd0, wea_o}, 32'd0);
    chk("rst_addr", 32'(addra_o), 32'd0);
    chk("rst_data", 32'(dia_o), 32'd0);
    chk("rst_sa_start", {31'd0, sa_start_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_ready", {31'd0, s_ready_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full 25x16 load, valid held high.
    do_start(25, 16);
    chk("load_ready", {31'd0, s_ready_o}, 32'd1);
    send_bytes(400, 400, 100, 1'b0);
    check_after_load("full", 1, 1'b0);
    conv_done_pulse();
    chk("full_idle", {31'd0, busy_o}, 32'd0);

    // Same load with a 50% valid duty cycle.
    do_start(25, 16);
    send_bytes(400, 400, 50, 1'b0);
    check_after_load("gappy", 2, 1'b0);
    conv_done_pulse();

    // Deepest column: 256 rows x 1 column.
    do_start(256, 1);
    send_bytes(256, 256, 80, 1'b1);
    check_after_load("deep", 3, 1'b0);
    conv_done_pulse();

    // Early last on byte 5 of a 4x2 load.
    do_start(4, 2);
    send_bytes(5, 5, 100, 1'b0);
    check_after_load("early_last", 4, 1'b1);
    chk("early_last_addr", 32'(addra_o), 32'h100);
    conv_done_pulse();

    // Valid start clears err; start pulsed in WAIT is ignored.
    do_start(1, 1);
    chk("start_clears_err", {31'd0, err_o}, 32'd0);
    send_bytes(1, 1, 100, 1'b0);
    check_after_load("one", 5, 1'b0);
    do_start(5, 5);
    chk("wait_start_busy", {31'd0, busy_o}, 32'd1);
    chk("wait_start_ready", {31'd0, s_ready_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("wait_start_no_sa", 32'(sa_cnt), 32'd5);
    conv_done_pulse();
    chk("wait_to_idle", {31'd0, busy_o}, 32'd0);
    do_start(3, 2);
    send_bytes(6, 6, 70, 1'b0);
    check_after_load("after_wait", 6, 1'b0);
    conv_done_pulse();

    // Illegal configurations.
    do_start(4, 0);
    chk("cols0_err", {31'd0, err_o}, 32'd1);
    chk("cols0_busy", {31'd0, busy_o}, 32'd0);
    chk("cols0_ready", {31'd0, s_ready_o}, 32'd0);
    do_start(1, 1);
    chk("recover_err", {31'd0, err_o}, 32'd0);
    send_bytes(1, 1, 100, 1'b0);
    check_after_load("recover", 7, 1'b0);
    conv_done_pulse();
    do_start(257, 1);
    chk("rows257_err", {31'd0, err_o}, 32'd1);
    chk("rows257_busy", {31'd0, busy_o}, 32'd0);
    do_start(1, 17);
    chk("cols17_busy", {31'd0, busy_o}, 32'd0);

    // Final beat without s_last: error, extra data not accepted.
    do_start(2, 1);
    send_bytes(2, 0, 100, 1'b0);
    check_after_load("no_last", 8, 1'b1);
    conv_done_pulse();

    // Reset in the middle of a load.
    sa_before = sa_cnt;
    do_start(25, 16);
    send_bytes(10, 0, 100, 1'b0);
    s_valid_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wea", {31'd0, wea_o}, 32'd0);
    chk("mid_rst_addr", 32'(addra_o), 32'd0);
    chk("mid_rst_data", 32'(dia_o), 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, s_ready_o}, 32'd0);
    chk("mid_rst_sa", {31'd0, sa_start_o}, 32'd0);
    s_valid_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_sa", 32'(sa_cnt), 32'(sa_before));
    chk("mid_rst_idle", {31'd0, busy_o}, 32'd0);

    // Counting pattern 1..400 (mod 256) for the checksum.
    do_start(25, 16);
    send_bytes(400, 400, 100, 1'b1);
    check_after_load("count", sa_before + 1, 1'b0);
    ref_sum = '0;
    for (int i = 1; i <= 400; i++) ref_sum = ref_sum + 16'(i % 256);
`ifdef WT_LOAD_CHECKSUM_EN
    chk("checksum_formula", 32'(checksum_o), 32'(ref_sum));
`endif
    conv_done_pulse();
    chk("final_idle", {31'd0, busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wt_load_ctrl.md
Name: wt_load_ctrl

Overview:
Sequencer that fills the systolic-array weight BRAM from a byte stream before each conv layer, then hands off to the SA controller. It accepts bytes over a valid/ready stream and generates BRAM write port A signals. Write address layout is {column[3:0], row[7:0]}, with rows filled fastest. It pulses the SA start once every programmed location is written, then holds off further loads until the layer's conv finishes.

Parameters:
- COL_NUM, 16, number of SA weight columns (BRAM column field is 4 bits).
- ROW_DEPTH, 256, rows per column (BRAM row field is 8 bits).
- DATA_WIDTH, 8, weight byte width.
- ADDR_WIDTH, 12, BRAM port A address width; must equal 4+8.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start_i  input  1  begin a load; sampled only in IDLE
- cfg_rows_i  input  9  rows per column, 1..256; latched at start
- cfg_cols_i  input  5  columns to load, 1..16; latched at start
- s_valid_i  input  1  stream byte valid
- s_data_i  input  DATA_WIDTH  stream byte
- s_last_i  input  1  final byte of the layer's weight set
- s_ready_o  output  1  stream ready
- conv_done_i  input  1  layer conv finished (from SA controller)
- wea_o  output  1  BRAM write enable
- addra_o  output  ADDR_WIDTH  BRAM write address
- dia_o  output  DATA_WIDTH  BRAM write data
- sa_start_o  output  1  one-cycle start pulse to SA controller
- busy_o  output  1  high whenever state != IDLE
- err_o  output  1  sticky error flag; cleared by an accepted start

Behaviour:
- Reset (asynchronous, rst=1): state IDLE, all outputs 0, row/col counters 0, latched config 0.
- State IDLE:
  - start_i=1 with rows in 1..256 and cols in 1..16: latch config, clear err_o, clear counters, go to LOAD.
  - start_i=1 with zero or out-of-range config: set err_o, stay IDLE, no sa_start_o.
- State LOAD:
  - s_ready_o=1 (combinational from state).
  - Beat accepted when s_valid_i && s_ready_o.
  - Registered write, latency 1: the cycle after a beat, wea_o=1, addra_o={col,row}, dia_o=byte. Otherwise wea_o=0; addra_o/dia_o hold their last value.
  - Counter on each beat: row+1. When row==rows-1, row wraps to 0 and col+1.
  - Final beat is row==rows-1 && col==cols-1.
    - Final beat with s_last_i=1: go to DONE.
    - Final beat with s_last_i=0: set err_o, go to DONE. The extra bytes are not consumed.
  - s_last_i=1 on a non-final beat: set err_o, go to DONE. The byte is written; remaining locations keep stale contents.
  - No beat accepted: counters hold, no write.
- State DONE (one cycle): s_ready_o=0. sa_start_o=1 in this cycle, so the pulse coincides with or follows the final wea_o and the last write is committed. Go to WAIT.
- State WAIT: s_ready_o=0. Go to IDLE when conv_done_i=1.
  - conv_done_i in any other state is ignored.
  - start_i outside IDLE is ignored (no queuing).
- busy_o=1 in LOAD, DONE and WAIT.
- Reset asserted mid-LOAD: immediate return to IDLE. A partially written BRAM is not invalidated, and no sa_start_o is produced.

Optional Feature:
- Macro: WT_LOAD_CHECKSUM_EN.
- Defined:
  - Adds output checksum_o [15:0]: modulo-2^16 sum of all accepted bytes (zero-extended) since the last accepted start.
  - checksum_o is cleared on accepted start, updates one cycle after each beat, and is stable from DONE until the next start.
  - Reset value 0.
- Undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package wt_ctrl_pkg holds:
  - state enum {IDLE, LOAD, DONE, WAIT};
  - constants COL_BITS=4, ROW_BITS=8;
  - address-pack function {col,row}.
- Sub-module wt_addr_gen: row/col counters with clear, step, latched bounds, and a final-beat flag. The FSM and stream handshake stay in the top module.

Test Plan:
- rows=25, cols=16, 400 bytes with valid held high and last on byte 400:
  - 400 writes at addresses 0x000–0x018, 0x100–0x118, …, 0xF00–0xF18;
  - data matches the stream;
  - one sa_start_o pulse;
  - err_o=0.
- Same load with s_valid_i toggling 50%: identical write sequence; no write in cycles without a beat; sa_start_o only after the 400th write.
- rows=4, cols=2, last asserted on byte 5: byte 5 written at 0x100, err_o=1, DONE entered, sa_start_o pulses, s_ready_o drops.
- start_i with cols=0: err_o=1, busy_o=0, s_ready_o stays 0. A later valid start (rows=1, cols=1) clears err_o.
- After DONE, start_i pulsed in WAIT: ignored. conv_done_i returns to IDLE; a new start then loads normally.
- rst asserted after 10 beats of a 400-byte load: outputs 0 asynchronously, IDLE, no sa_start_o. With WT_LOAD_CHECKSUM_EN, bytes 1..400 (mod 256 pattern) give the expected 16-bit sum.
